i2c_master_tx: RTL and testbench

Write-only I2C master transmitter: the initiating end of the bus whose byte, ACK and STOP timing our slave-side receive path tracks. It generates START, a 7-bit address with R/W=0, and a stream of data bytes taken through a valid/ready handshake, samples each slave ACK, and ends with STOP. It sits between the controller FSM and the SCL/SDA pad logic. Pads are open-drain: an output value of 1 means release, and 0 means drive low.

---
 rtl/i2c_master_tx.sv | 170 +++++++++++++++++
 tb/tb_i2c_master_tx.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_tx.sv
// Write-only I2C master: START, 7-bit address (R/W=0), streamed data bytes with
// per-byte ACK sampling, then STOP. Open-drain drives: 1 = release, 0 = pull low.
module i2c_master_tx #(
    parameter int QTR = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [6:0] tx_addr,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       sda_out,
    output logic       busy,
    output logic       done,
    output logic       nack_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_ACK,
        S_STOP
    } state_t;

    localparam logic [7:0] QTR_LAST = 8'(QTR - 1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_qcnt, w_qcnt_nxt;
    logic [1:0] r_phase, w_phase_nxt;
    logic [2:0] r_bitcnt, w_bitcnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_ack;
    logic       r_busy, w_busy_nxt;
    logic       r_nack, w_nack_nxt;
    logic       r_scl, r_sda, r_done, r_ready;
    logic       w_scl_nxt, w_sda_nxt, w_done_nxt, w_ready_nxt;
    logic       w_tick, w_accept, w_slot_end, w_load, w_ack_smp;

    // A start on the done cycle is dropped: state is already IDLE there.
    assign w_tick     = (r_state != S_IDLE) && (r_qcnt == QTR_LAST);
    assign w_accept   = (r_state == S_IDLE) && tx_start && !r_done;
    assign w_slot_end = w_tick && (r_phase == 2'd3);
    assign w_ack_smp  = (r_state == S_ACK) && w_tick && (r_phase == 2'd2);
    assign w_load     = (r_state == S_ACK) && w_slot_end && r_ack && byte_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_START;
            S_START: if (w_tick && r_phase == 2'd1) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_slot_end && r_bitcnt == 3'd7) w_state_nxt = S_ACK;
            S_ACK: begin
                if (w_slot_end) begin
                    if (r_ack && byte_valid) w_state_nxt = S_SHIFT;
                    else                     w_state_nxt = S_STOP;
                end
            end
            S_STOP:  if (w_slot_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        w_qcnt_nxt   = (r_state == S_IDLE || w_tick) ? 8'd0 : r_qcnt + 8'd1;
        w_phase_nxt  = r_phase;
        if (r_state == S_IDLE || w_state_nxt != r_state) w_phase_nxt = 2'd0;
        else if (w_tick)                                 w_phase_nxt = r_phase + 2'd1;
        w_bitcnt_nxt = r_bitcnt;
        if (r_state == S_SHIFT && w_slot_end) w_bitcnt_nxt = r_bitcnt + 3'd1;
        w_shift_nxt  = r_shift;
        if (w_accept)                              w_shift_nxt = {tx_addr, 1'b0};
        else if (r_state == S_SHIFT && w_slot_end) w_shift_nxt = {r_shift[6:0], 1'b0};
        else if (w_load)                           w_shift_nxt = byte_data;
        w_busy_nxt   = r_busy;
        if (w_accept)                             w_busy_nxt = 1'b1;
        else if (r_state == S_STOP && w_slot_end) w_busy_nxt = 1'b0;
        w_nack_nxt   = r_nack;
        if (w_accept)                                    w_nack_nxt = 1'b0;
        else if (r_state == S_ACK && w_slot_end && !r_ack) w_nack_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_qcnt   <= 8'd0;
            r_phase  <= 2'd0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_nack   <= 1'b0;
        end else begin
            r_qcnt   <= w_qcnt_nxt;
            r_phase  <= w_phase_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_busy   <= w_busy_nxt;
            r_nack   <= w_nack_nxt;
            if (w_ack_smp) r_ack <= ~sda_in;
        end
    end

    // Pad levels are decoded from the next state/phase so the registered
    // outputs line up with the state they belong to, with no extra cycle.
    always_comb begin
        w_scl_nxt   = 1'b1;
        w_sda_nxt   = 1'b1;
        w_done_nxt  = (r_state == S_STOP) && w_slot_end;
        w_ready_nxt = w_load;
        case (w_state_nxt)
            S_IDLE: begin
                w_scl_nxt = 1'b1;
                w_sda_nxt = 1'b1;
            end
            S_START: begin
                w_scl_nxt = 1'b1;
                w_sda_nxt = 1'b0;
            end
            S_SHIFT: begin
                w_scl_nxt = w_phase_nxt[1];
                w_sda_nxt = w_shift_nxt[7];
            end
            S_ACK: begin
                w_scl_nxt = w_phase_nxt[1];
                w_sda_nxt = 1'b1;
            end
            S_STOP: begin
                w_scl_nxt = w_phase_nxt[1];
                w_sda_nxt = (w_phase_nxt == 2'd3);
            end
            default: begin
                w_scl_nxt = 1'b1;
                w_sda_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl   <= 1'b1;
            r_sda   <= 1'b1;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_scl   <= w_scl_nxt;
            r_sda   <= w_sda_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    assign scl_out    = r_scl;
    assign sda_out    = r_sda;
    assign busy       = r_busy;
    assign done       = r_done;
    assign byte_ready = r_ready;
    assign nack_err   = r_nack;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: expected frame bytes are queued as each transaction
// is launched and matched against the bits seen on SCL rising edges.
module tb_i2c_master_tx;

    localparam int QTR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [6:0] tx_addr = 7'h00;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       sda_in = 1'b0;
    logic       scl_out, sda_out, busy, done, nack_err;

    i2c_master_tx #(.QTR(QTR)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_addr(tx_addr),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .sda_in(sda_in), .scl_out(scl_out), .sda_out(sda_out),
        .busy(busy), .done(done), .nack_err(nack_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int rdy_cnt = 0;
    int hi_fall = 0;
    int hi_rise = 0;
    int rel_bad = 0;
    int tail = 0;
    logic p_scl, p_sda;
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       bitq[$];

    always @(posedge clk) cyc++;

    // Bus monitor and byte source
    always @(negedge clk) begin
        if (!rst) begin
            if (scl_out === 1'b1 && p_scl === 1'b0) bitq.push_back(sda_out);
            if (sda_out !== p_sda && scl_out === 1'b1) begin
                if (sda_out) hi_rise++;
                else         hi_fall++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (byte_ready === 1'b1) begin
                rdy_cnt++;
                if (src_q.size() > 0) src_q.delete(0);
            end
        end
        p_scl = scl_out;
        p_sda = sda_out;
        byte_valid = (src_q.size() > 0);
        byte_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, want summary before %0t", $time);
        $fatal(1);
    end

    function automatic int exp_len(input int n);
        return (2 + 36 * (n + 1) + 4) * QTR;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_txn(input logic [6:0] a);
        bitq.delete();
        exp_q.push_back({a, 1'b0});
        tx_addr  = a;
        tx_start = 1'b1;
        step();
        tx_start  = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        int d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Slices captured bits into 8 data bits + 1 ACK-slot bit per byte.
    task automatic drain_bits();
        logic [7:0] b;
        b = 8'h00;
        got_q.delete();
        rel_bad = 0;
        while (bitq.size() >= 9) begin
            for (int k = 0; k < 8; k++) b = {b[6:0], bitq.pop_front()};
            if (bitq.pop_front() !== 1'b1) rel_bad++;
            got_q.push_back(b);
        end
        tail = bitq.size();
        bitq.delete();
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_chk++; if (scl_out !== 1'b1) begin $display("FAIL reset_scl: got %b want 1", scl_out); n_fail++; end
        n_chk++; if (sda_out !== 1'b1) begin $display("FAIL reset_sda: got %b want 1", sda_out); n_fail++; end
        n_chk++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); n_fail++; end
        n_chk++; if (done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", done); n_fail++; end
        n_chk++; if (byte_ready !== 1'b0) begin $display("FAIL reset_ready: got %b want 0", byte_ready); n_fail++; end
        n_chk++; if (nack_err !== 1'b0) begin $display("FAIL reset_nack: got %b want 0", nack_err); n_fail++; end
        rst = 1'b0;
        step();
    endtask

    task automatic test_addr_only();
        int r0 = rdy_cnt;
        bit ok;
        logic [7:0] e, g;
        sda_in = 1'b0;
        start_txn(7'h50);
        n_chk++;
        if (busy !== 1'b1 || scl_out !== 1'b1 || sda_out !== 1'b0) begin
            $display("FAIL addr_start: busy=%b scl=%b sda=%b, want 1 1 0", busy, scl_out, sda_out);
            n_fail++;
        end
        while (cyc < start_cyc + 2 * QTR - 1) step();
        n_chk++; if (scl_out !== 1'b1) begin $display("FAIL addr_scl_pre_fall: got %b want 1", scl_out); n_fail++; end
        step();
        n_chk++; if (scl_out !== 1'b0) begin $display("FAIL addr_first_fall: got %b want 0", scl_out); n_fail++; end
        wait_done(400, ok);
        n_chk++; if (!ok) begin $display("FAIL addr_done_timeout: got no done, want done"); n_fail++; end
        n_chk++;
        if (done_cyc - start_cyc != exp_len(0)) begin
            $display("FAIL addr_len: got %0d want %0d", done_cyc - start_cyc, exp_len(0));
            n_fail++;
        end
        n_chk++; if (nack_err !== 1'b0) begin $display("FAIL addr_nack: got %b want 0", nack_err); n_fail++; end
        n_chk++; if (rdy_cnt - r0 != 0) begin $display("FAIL addr_ready: got %0d pulses want 0", rdy_cnt - r0); n_fail++; end
        drain_bits();
        n_chk++;
        if (got_q.size() != exp_q.size() || rel_bad != 0 || tail != 1) begin
            $display("FAIL addr_frame: bytes=%0d rel_bad=%0d tail=%0d, want bytes=%0d rel_bad=0 tail=1",
                     got_q.size(), rel_bad, tail, exp_q.size());
            n_fail++;
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_chk++; if (g !== e) begin $display("FAIL addr_byte: got %h want %h", g, e); n_fail++; end
        end
        exp_q.delete();
        step();
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL addr_after_done: done=%b busy=%b, want 0 0", done, busy);
            n_fail++;
        end
    endtask

    task automatic test_data_bytes();
        int r0 = rdy_cnt;
        int f0 = hi_fall;
        int u0 = hi_rise;
        bit ok;
        logic [7:0] e, g;
        sda_in = 1'b0;
        src_q.push_back(8'hA5);
        src_q.push_back(8'h0F);
        step();
        start_txn(7'h3C);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h0F);
        wait_done(1000, ok);
        n_chk++; if (!ok) begin $display("FAIL data_done_timeout: got no done, want done"); n_fail++; end
        n_chk++;
        if (done_cyc - start_cyc != exp_len(2)) begin
            $display("FAIL data_len: got %0d want %0d", done_cyc - start_cyc, exp_len(2));
            n_fail++;
        end
        n_chk++; if (rdy_cnt - r0 != 2) begin $display("FAIL data_ready: got %0d pulses want 2", rdy_cnt - r0); n_fail++; end
        n_chk++; if (hi_fall - f0 != 1) begin $display("FAIL data_sda_fall_hi: got %0d want 1", hi_fall - f0); n_fail++; end
        n_chk++; if (hi_rise - u0 != 1) begin $display("FAIL data_sda_rise_hi: got %0d want 1", hi_rise - u0); n_fail++; end
        n_chk++; if (nack_err !== 1'b0) begin $display("FAIL data_nack: got %b want 0", nack_err); n_fail++; end
        drain_bits();
        n_chk++;
        if (got_q.size() != exp_q.size() || rel_bad != 0 || tail != 1) begin
            $display("FAIL data_frame: bytes=%0d rel_bad=%0d tail=%0d, want bytes=%0d rel_bad=0 tail=1",
                     got_q.size(), rel_bad, tail, exp_q.size());
            n_fail++;
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_chk++; if (g !== e) begin $display("FAIL data_byte: got %h want %h", g, e); n_fail++; end
        end
        exp_q.delete();
        src_q.delete();
        step();
    endtask

    task automatic test_nack();
        int r0 = rdy_cnt;
        bit ok;
        logic [7:0] e, g;
        sda_in = 1'b1;
        src_q.push_back(8'h11);
        step();
        start_txn(7'h2A);
        wait_done(400, ok);
        n_chk++; if (!ok) begin $display("FAIL nack_done_timeout: got no done, want done"); n_fail++; end
        n_chk++;
        if (done_cyc - start_cyc != exp_len(0)) begin
            $display("FAIL nack_len: got %0d want %0d", done_cyc - start_cyc, exp_len(0));
            n_fail++;
        end
        n_chk++; if (nack_err !== 1'b1) begin $display("FAIL nack_flag: got %b want 1", nack_err); n_fail++; end
        n_chk++; if (rdy_cnt - r0 != 0) begin $display("FAIL nack_ready: got %0d pulses want 0", rdy_cnt - r0); n_fail++; end
        drain_bits();
        n_chk++;
        if (got_q.size() != exp_q.size() || rel_bad != 0 || tail != 1) begin
            $display("FAIL nack_frame: bytes=%0d rel_bad=%0d tail=%0d, want bytes=%0d rel_bad=0 tail=1",
                     got_q.size(), rel_bad, tail, exp_q.size());
            n_fail++;
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_chk++; if (g !== e) begin $display("FAIL nack_byte: got %h want %h", g, e); n_fail++; end
        end
        exp_q.delete();
        repeat (20) step();
        n_chk++; if (nack_err !== 1'b1) begin $display("FAIL nack_sticky: got %b want 1", nack_err); n_fail++; end
        src_q.delete();
        sda_in = 1'b0;
        step();
        start_txn(7'h2A);
        n_chk++; if (nack_err !== 1'b0) begin $display("FAIL nack_clear: got %b want 0", nack_err); n_fail++; end
        wait_done(400, ok);
        n_chk++; if (!ok || nack_err !== 1'b0) begin $display("FAIL nack_next_txn: ok=%b nack=%b, want 1 0", ok, nack_err); n_fail++; end
        drain_bits();
        exp_q.delete();
        step();
    endtask

    task automatic test_reset_mid();
        int r0 = rdy_cnt;
        int d0;
        bit ok;
        logic [7:0] e, g;
        sda_in = 1'b0;
        src_q.push_back(8'hC3);
        step();
        start_txn(7'h2A);
        // Middle (phase 2) of the third data bit: quarter 2 + 36 + 8 + 2.
        while (cyc < start_cyc + 48 * QTR) step();
        n_chk++;
        if (busy !== 1'b1 || scl_out !== 1'b1) begin
            $display("FAIL rstmid_pre: busy=%b scl=%b, want 1 1", busy, scl_out);
            n_fail++;
        end
        rst = 1'b1;
        step();
        n_chk++;
        if (scl_out !== 1'b1 || sda_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL rstmid_release: scl=%b sda=%b busy=%b done=%b, want 1 1 0 0", scl_out, sda_out, busy, done);
            n_fail++;
        end
        rst = 1'b0;
        exp_q.delete();
        bitq.delete();
        n_chk++; if (rdy_cnt - r0 != 1) begin $display("FAIL rstmid_ready: got %0d pulses want 1", rdy_cnt - r0); n_fail++; end
        d0 = done_cnt;
        repeat (exp_len(1)) step();
        n_chk++;
        if (done_cnt != d0 || busy !== 1'b0 || scl_out !== 1'b1 || sda_out !== 1'b1) begin
            $display("FAIL rstmid_quiet: done_pulses=%0d busy=%b scl=%b sda=%b, want 0 0 1 1",
                     done_cnt - d0, busy, scl_out, sda_out);
            n_fail++;
        end
        start_txn(7'h50);
        wait_done(400, ok);
        n_chk++;
        if (!ok || done_cyc - start_cyc != exp_len(0)) begin
            $display("FAIL rstmid_fresh_len: ok=%b len=%0d, want 1 %0d", ok, done_cyc - start_cyc, exp_len(0));
            n_fail++;
        end
        drain_bits();
        n_chk++;
        if (got_q.size() != exp_q.size() || rel_bad != 0 || tail != 1) begin
            $display("FAIL rstmid_frame: bytes=%0d rel_bad=%0d tail=%0d, want bytes=%0d rel_bad=0 tail=1",
                     got_q.size(), rel_bad, tail, exp_q.size());
            n_fail++;
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_chk++; if (g !== e) begin $display("FAIL rstmid_byte: got %h want %h", g, e); n_fail++; end
        end
        exp_q.delete();
        step();
    endtask

    task automatic test_start_ignored();
        int d0 = done_cnt;
        bit ok;
        logic [7:0] e, g;
        sda_in = 1'b0;
        start_txn(7'h50);
        repeat (30) step();
        tx_addr  = 7'h11;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        wait_done(400, ok);
        n_chk++;
        if (!ok || done_cyc - start_cyc != exp_len(0) || done_cnt != d0 + 1) begin
            $display("FAIL ign_busy: ok=%b len=%0d pulses=%0d, want 1 %0d 1", ok, done_cyc - start_cyc, done_cnt - d0, exp_len(0));
            n_fail++;
        end
        drain_bits();
        n_chk++;
        if (got_q.size() != 1 || got_q[0] !== 8'hA0) begin
            $display("FAIL ign_frame: bytes=%0d, want 1 byte of a0", got_q.size());
            n_fail++;
        end
        exp_q.delete();
        // Pulse held across the done cycle and the one after it.
        tx_addr  = 7'h50;
        tx_start = 1'b1;
        step();
        n_chk++;
        if (busy !== 1'b0 || done_cnt != d0 + 1) begin
            $display("FAIL ign_on_done: busy=%b pulses=%0d, want 0 1", busy, done_cnt - d0);
            n_fail++;
        end
        bitq.delete();
        exp_q.push_back(8'hA0);
        step();
        tx_start  = 1'b0;
        start_cyc = cyc;
        n_chk++; if (busy !== 1'b1) begin $display("FAIL ign_after_done: busy=%b want 1", busy); n_fail++; end
        wait_done(400, ok);
        n_chk++;
        if (!ok || done_cyc - start_cyc != exp_len(0) || done_cnt != d0 + 2) begin
            $display("FAIL ign_second: ok=%b len=%0d pulses=%0d, want 1 %0d 2", ok, done_cyc - start_cyc, done_cnt - d0, exp_len(0));
            n_fail++;
        end
        drain_bits();
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_chk++; if (g !== e) begin $display("FAIL ign_byte: got %h want %h", g, e); n_fail++; end
        end
        exp_q.delete();
        step();
    endtask

    initial begin
        test_reset();
        test_addr_only();
        test_data_bytes();
        test_nack();
        test_reset_mid();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
